// File: rtl/instr_encoder.sv
// RV32I instruction encoder: turns op/register/immediate requests into words for an imem writer.
// Optional ENC_RANGE_CHECK_EN drops and flags requests whose immediate does not fit its field.
module instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_op,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   input  logic        in_last,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   output logic        done,
   output logic        err_op,
   output logic        err_range
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [3:0] FmtBad   = 4'd0;
   localparam logic [3:0] FmtR     = 4'd1;
   localparam logic [3:0] FmtI     = 4'd2;
   localparam logic [3:0] FmtSh    = 4'd3;
   localparam logic [3:0] FmtLd    = 4'd4;
   localparam logic [3:0] FmtSt    = 4'd5;
   localparam logic [3:0] FmtBr    = 4'd6;
   localparam logic [3:0] FmtJal   = 4'd7;
   localparam logic [3:0] FmtJalr  = 4'd8;
   localparam logic [3:0] FmtLui   = 4'd9;
   localparam logic [3:0] FmtAuipc = 4'd10;

   logic [1:0]  state_q, state_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_instr_q;
   logic [31:0] addr_q, addr_d;
   logic        err_op_q;
   logic        last_q, last_d;
   logic [3:0]  fmt;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] enc_word;
   logic        op_bad, range_bad, accept, emit, handshake;

   always_comb begin
      fmt = FmtBad;
      f3  = 3'd0;
      f7  = 7'd0;
      case (in_op)
         6'd0:  fmt = FmtR;
         6'd1:  begin fmt = FmtR;  f7 = 7'h20; end
         6'd2:  begin fmt = FmtR;  f3 = 3'd4; end
         6'd3:  begin fmt = FmtR;  f3 = 3'd6; end
         6'd4:  begin fmt = FmtR;  f3 = 3'd7; end
         6'd5:  begin fmt = FmtR;  f3 = 3'd1; end
         6'd6:  begin fmt = FmtR;  f3 = 3'd5; end
         6'd7:  begin fmt = FmtR;  f3 = 3'd5; f7 = 7'h20; end
         6'd8:  begin fmt = FmtR;  f3 = 3'd2; end
         6'd9:  begin fmt = FmtR;  f3 = 3'd3; end
         6'd10: fmt = FmtI;
         6'd11: begin fmt = FmtI;  f3 = 3'd4; end
         6'd12: begin fmt = FmtI;  f3 = 3'd6; end
         6'd13: begin fmt = FmtI;  f3 = 3'd7; end
         6'd14: begin fmt = FmtSh; f3 = 3'd1; end
         6'd15: begin fmt = FmtSh; f3 = 3'd5; end
         6'd16: begin fmt = FmtSh; f3 = 3'd5; f7 = 7'h20; end
         6'd17: begin fmt = FmtI;  f3 = 3'd2; end
         6'd18: begin fmt = FmtI;  f3 = 3'd3; end
         6'd19: fmt = FmtLd;
         6'd20: begin fmt = FmtLd; f3 = 3'd1; end
         6'd21: begin fmt = FmtLd; f3 = 3'd2; end
         6'd22: begin fmt = FmtLd; f3 = 3'd4; end
         6'd23: begin fmt = FmtLd; f3 = 3'd5; end
         6'd24: fmt = FmtSt;
         6'd25: begin fmt = FmtSt; f3 = 3'd1; end
         6'd26: begin fmt = FmtSt; f3 = 3'd2; end
         6'd27: fmt = FmtBr;
         6'd28: begin fmt = FmtBr; f3 = 3'd1; end
         6'd29: begin fmt = FmtBr; f3 = 3'd4; end
         6'd30: begin fmt = FmtBr; f3 = 3'd5; end
         6'd31: begin fmt = FmtBr; f3 = 3'd6; end
         6'd32: begin fmt = FmtBr; f3 = 3'd7; end
         6'd33: fmt = FmtJal;
         6'd34: fmt = FmtJalr;
         6'd35: fmt = FmtLui;
         6'd36: fmt = FmtAuipc;
         default: fmt = FmtBad;
      endcase
   end

   always_comb begin
      enc_word = 32'd0;
      case (fmt)
         FmtR:     enc_word = {f7, in_rs2, in_rs1, f3, in_rd, 7'b0110011};
         FmtI:     enc_word = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0010011};
         FmtSh:    enc_word = {f7, in_imm[4:0], in_rs1, f3, in_rd, 7'b0010011};
         FmtLd:    enc_word = {in_imm[11:0], in_rs1, f3, in_rd, 7'b0000011};
         FmtSt:    enc_word = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], 7'b0100011};
         FmtBr:    enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1],
                               in_imm[11], 7'b1100011};
         FmtJal:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd,
                               7'b1101111};
         FmtJalr:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b1100111};
         FmtLui:   enc_word = {in_imm[19:0], in_rd, 7'b0110111};
         FmtAuipc: enc_word = {in_imm[19:0], in_rd, 7'b0010111};
         default:  enc_word = 32'd0;
      endcase
   end

   assign in_ready  = (state_q != StDone) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign op_bad    = (fmt == FmtBad);
   assign emit      = accept && !op_bad && !range_bad;
   assign handshake = out_valid_q && out_ready;

   assign out_valid_d = emit || (out_valid_q && !out_ready);
   assign addr_d      = handshake ? addr_q + 32'd4 : addr_q;
   assign last_d      = last_q || (accept && in_last);

   // Done only once the final request has left the output register (sent or dropped).
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StRun: begin
            if (last_d && !out_valid_d) state_d = StDone;
            else if (accept)            state_d = StRun;
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         out_instr_q <= 32'd0;
         addr_q      <= BASE_ADDR;
         err_op_q    <= 1'b0;
         last_q      <= 1'b0;
      end else if (clr) begin
         state_q     <= StIdle;
         out_valid_q <= 1'b0;
         addr_q      <= BASE_ADDR;
         err_op_q    <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         addr_q      <= addr_d;
         last_q      <= last_d;
         if (emit)            out_instr_q <= enc_word;
         if (accept && op_bad) err_op_q   <= 1'b1;
      end
   end

`ifdef ENC_RANGE_CHECK_EN
   logic imm_fits;
   logic err_range_q;

   always_comb begin
      case (fmt)
         FmtI, FmtLd, FmtSt, FmtJalr: imm_fits = (&in_imm[31:11]) || !(|in_imm[31:11]);
         FmtSh:            imm_fits = !(|in_imm[31:5]);
         FmtBr:            imm_fits = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
         FmtJal:           imm_fits = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
         FmtLui, FmtAuipc: imm_fits = !(|in_imm[31:20]);
         default:          imm_fits = 1'b1;
      endcase
   end
   assign range_bad = !imm_fits;

   always_ff @(posedge clk) begin
      if (rst || clr)                       err_range_q <= 1'b0;
      else if (accept && !op_bad && range_bad) err_range_q <= 1'b1;
   end
   assign err_range = err_range_q;
`else
   logic unused_imm;
   assign unused_imm = ^in_imm[31:21];
   assign range_bad  = 1'b0;
   assign err_range  = 1'b0;
`endif

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_addr  = addr_q;
   assign done      = (state_q == StDone);
   assign err_op    = err_op_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal cases plus randomized traffic
// compared every cycle against a spec-level model. Honours ENC_RANGE_CHECK_EN like the DUT.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_2000;
`ifdef ENC_RANGE_CHECK_EN
   localparam bit RangeOn = 1'b1;
`else
   localparam bit RangeOn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, clr, in_valid, in_ready, in_last, out_valid, out_ready;
   logic [5:0]  in_op;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm, out_instr, out_addr;
   logic        done, err_op, err_range;

   int checks = 0;
   int failures = 0;

   instr_encoder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .done(done), .err_op(err_op), .err_range(err_range)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // Reference encoder built from field arithmetic.
   int unsigned alu_f3 [0:9] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
   int unsigned ld_f3  [0:4] = '{0, 1, 2, 4, 5};
   int unsigned br_f3  [0:5] = '{0, 1, 4, 5, 6, 7};
   logic [31:0] edge_imm [0:11] = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF,
                                    32'd4094, 32'd4096, 32'hFFFF_F000, 32'd31, 32'd32,
                                    32'h000F_FFFF, 32'h0010_0000, 32'h000F_FFFE};

   function automatic logic [31:0] ref_encode(input int unsigned op, input int unsigned rd,
                                              input int unsigned rs1, input int unsigned rs2,
                                              input logic [31:0] imm);
      int unsigned u = imm;
      int unsigned w, idx;
      if (op <= 9) begin
         w = 'h33 | rd << 7 | alu_f3[op] << 12 | rs1 << 15 | rs2 << 20 |
             ((op == 1 || op == 7) ? 'h20 : 0) << 25;
      end else if (op <= 18) begin
         idx = (op == 10) ? 0 : op - 9;
         if (op >= 14 && op <= 16)
            w = 'h13 | rd << 7 | alu_f3[idx] << 12 | rs1 << 15 | (u & 31) << 20 |
                ((op == 16) ? 'h20 : 0) << 25;
         else
            w = 'h13 | rd << 7 | alu_f3[idx] << 12 | rs1 << 15 | (u & 'hfff) << 20;
      end else if (op <= 23) begin
         w = 'h03 | rd << 7 | ld_f3[op - 19] << 12 | rs1 << 15 | (u & 'hfff) << 20;
      end else if (op <= 26) begin
         w = 'h23 | (u & 31) << 7 | (op - 24) << 12 | rs1 << 15 | rs2 << 20 |
             ((u >> 5) & 127) << 25;
      end else if (op <= 32) begin
         w = 'h63 | ((u >> 11) & 1) << 7 | ((u >> 1) & 15) << 8 | br_f3[op - 27] << 12 |
             rs1 << 15 | rs2 << 20 | ((u >> 5) & 63) << 25 | ((u >> 12) & 1) << 31;
      end else if (op == 33) begin
         w = 'h6f | rd << 7 | ((u >> 12) & 255) << 12 | ((u >> 11) & 1) << 20 |
             ((u >> 1) & 1023) << 21 | ((u >> 20) & 1) << 31;
      end else if (op == 34) begin
         w = 'h67 | rd << 7 | rs1 << 15 | (u & 'hfff) << 20;
      end else begin
         w = ((op == 35) ? 'h37 : 'h17) | rd << 7 | (u & 'hfffff) << 12;
      end
      return w;
   endfunction

   function automatic bit ref_fits(input int unsigned op, input logic [31:0] imm);
      int s = $signed(imm);
      if (op <= 9) return 1'b1;
      if (op >= 14 && op <= 16) return imm < 32;
      if (op <= 26 || op == 34) return s >= -2048 && s <= 2047;
      if (op <= 32) return s >= -4096 && s <= 4095 && !imm[0];
      if (op == 33) return s >= -1048576 && s <= 1048575 && !imm[0];
      return imm < 32'h0010_0000;
   endfunction

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 3))
         0:       return $urandom_range(0, 127) - 64;
         1:       return $urandom();
         2:       return edge_imm[$urandom_range(0, 11)];
         default: return $urandom_range(0, 1023) << 1;
      endcase
   endfunction

   // Behavioural model: state 0 idle, 1 run, 2 done.
   bit          live = 1'b0;
   bit          m_after_rst, m_valid, m_err_op, m_err_range, m_last;
   int unsigned m_state;
   logic [31:0] m_instr, m_addr;

   always @(posedge clk) begin : model
      int unsigned op;
      bit rdy;
      if (rst) begin
         live = 1'b1; m_after_rst = 1'b1; m_state = 0; m_valid = 1'b0; m_instr = 32'd0;
         m_addr = BASE; m_err_op = 1'b0; m_err_range = 1'b0; m_last = 1'b0;
      end else begin
         m_after_rst = 1'b0;
         if (clr) begin
            m_state = 0; m_valid = 1'b0; m_addr = BASE;
            m_err_op = 1'b0; m_err_range = 1'b0; m_last = 1'b0;
         end else if (live) begin
            rdy = (m_state != 2) && (!m_valid || out_ready);
            if (m_valid && out_ready) begin
               m_valid = 1'b0;
               m_addr  = m_addr + 32'd4;
            end
            if (in_valid && rdy) begin
               op = {26'd0, in_op};
               if (op > 36) m_err_op = 1'b1;
               else if (RangeOn && !ref_fits(op, in_imm)) m_err_range = 1'b1;
               else begin
                  m_valid = 1'b1;
                  m_instr = ref_encode(op, {27'd0, in_rd}, {27'd0, in_rs1}, {27'd0, in_rs2},
                                       in_imm);
               end
               if (in_last) m_last = 1'b1;
               if (m_state == 0) m_state = 1;
            end
            if (m_last && !m_valid) m_state = 2;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk1("in_ready", in_ready, (m_state != 2) && (!m_valid || out_ready));
         chk1("out_valid", out_valid, m_valid);
         chk1("done", done, m_state == 2);
         chk1("err_op", err_op, m_err_op);
         chk1("err_range", err_range, m_err_range);
         if (m_valid) begin
            chk("out_instr", out_instr, m_instr);
            chk("out_addr", out_addr, m_addr);
         end
         if (m_after_rst) begin
            chk("rst_out_instr", out_instr, 32'd0);
            chk("rst_out_addr", out_addr, BASE);
         end
      end
   end

   logic [31:0] log_instr [$];
   logic [31:0] log_addr [$];
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         log_instr.push_back(out_instr);
         log_addr.push_back(out_addr);
      end
   end

   task automatic chk_log(input string name, input int idx, input logic [31:0] ei,
                          input logic [31:0] ea);
      if (log_instr.size() <= idx) begin
         chk({name, "_count"}, 32'(log_instr.size()), 32'(idx + 1));
      end else begin
         chk({name, "_instr"}, log_instr[idx], ei);
         chk({name, "_addr"}, log_addr[idx], ea);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last);
      bit ok = 1'b0;
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_imm = imm; in_last = last;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!ok) chk1("send_timeout", 1'b0, 1'b1);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0;
      in_rs2 = '0; in_imm = '0; in_last = 1'b0; out_ready = 1'b1;
      step(3);
      rst = 1'b0;
      @(negedge clk);
      chk1("reset_in_ready", in_ready, 1'b1);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_instr", out_instr, 32'd0);
      chk("reset_out_addr", out_addr, BASE);
      chk1("reset_done", done, 1'b0);
      chk1("reset_err_op", err_op, 1'b0);
      step(1);

      // add x3, x1, x2 visible one cycle after accept
      send(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      @(negedge clk);
      chk1("add_valid", out_valid, 1'b1);
      chk("add_instr", out_instr, 32'h0020_81B3);
      chk("add_addr", out_addr, BASE);
      step(1);

      // addi -1 then beq -4 back to back
      n = log_instr.size();
      send(6'd10, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
      send(6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
      step(2);
      chk_log("addi", n, 32'hFFF0_0293, BASE + 4);
      chk_log("beq", n + 1, 32'hFE20_8EE3, BASE + 8);

      // backpressure: word held for 3 cycles
      out_ready = 1'b0;
      send(6'd3, 5'd7, 5'd8, 5'd9, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_instr", out_instr, 32'h0094_63B3);
         chk("hold_addr", out_addr, BASE + 12);
         chk1("hold_in_ready", in_ready, 1'b0);
         step(1);
      end
      out_ready = 1'b1;

      // illegal op consumed without output
      n = log_instr.size();
      send(6'd45, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
      @(negedge clk);
      chk1("badop_err", err_op, 1'b1);
      chk1("badop_no_valid", out_valid, 1'b0);
      step(1);
      send(6'd13, 5'd1, 5'd2, 5'd0, 32'h0000_00F0, 1'b0);
      step(2);
      chk_log("or_after_hold", n, 32'h0094_63B3, BASE + 12);
      chk_log("andi", n + 1, 32'h0F01_7093, BASE + 16);

      // addi 2048: out of range
      n = log_instr.size();
      send(6'd10, 5'd0, 5'd0, 5'd0, 32'd2048, 1'b0);
      step(2);
`ifdef ENC_RANGE_CHECK_EN
      chk1("range_err", err_range, 1'b1);
      chk("range_dropped", 32'(log_instr.size()), 32'(n));
`else
      chk_log("range_trunc", n, 32'h8000_0013, BASE + 20);
      chk1("range_err_tied", err_range, 1'b0);
`endif

      // last request, then clr restarts at BASE
      send(6'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
      step(2);
      @(negedge clk);
      chk1("last_done", done, 1'b1);
      chk1("last_in_ready", in_ready, 1'b0);
      step(1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      @(negedge clk);
      chk1("clr_done", done, 1'b0);
      chk1("clr_in_ready", in_ready, 1'b1);
      chk1("clr_err_op", err_op, 1'b0);
      step(1);
      n = log_instr.size();
      send(6'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0);
      step(2);
      chk_log("sub_after_clr", n, 32'h4031_00B3, BASE);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         clr       = ($urandom_range(0, 49) == 0);
         in_valid  = ($urandom_range(0, 2) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_op     = 6'($urandom_range(0, 40));
         in_rd     = 5'($urandom());
         in_rs1    = 5'($urandom());
         in_rs2    = 5'($urandom());
         in_imm    = rand_imm();
         in_last   = ($urandom_range(0, 39) == 0);
         step(1);
      end
      rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      step(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
